// File: rtl/led_trail_pwm.sv
// led_trail_pwm: per-channel PWM LED driver with global brightness steps and afterglow decay.
module led_trail_pwm #(
  parameter int   CLK_IN_MHZ   = 125,
  parameter int   N_LEDS       = 8,
  parameter int   DECAY_FRAMES = 2000,
  parameter logic LED_POLARITY = 1'b1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [N_LEDS-1:0] led_i,
  input  logic              bright_up_i,
  input  logic              bright_dn_i,
  output logic [N_LEDS-1:0] led_o,
  output logic [3:0]        bright_o,
  output logic              frame_o
);
  localparam int PS_W = (CLK_IN_MHZ > 1) ? $clog2(CLK_IN_MHZ) : 1;
  localparam int DC_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_IN_MHZ - 1);
  localparam logic [DC_W-1:0] DC_MAX = DC_W'(DECAY_FRAMES - 1);

  logic [PS_W-1:0]   r_ps;
  logic [3:0]        r_pwm;
  logic [DC_W-1:0]   r_dc;
  logic [3:0]        r_bright;
  logic              r_pend_v;
  logic              r_pend_up;
  logic              r_frame;
  logic [N_LEDS-1:0] r_led;
  logic [3:0]        r_lvl [N_LEDS];

  logic              w_tick;
  logic              w_frame;
  logic              w_decay;
  logic              w_req;
  logic [3:0]        w_bright_nxt;
  logic [3:0]        w_lvl_nxt [N_LEDS];
  logic [N_LEDS-1:0] w_on;

  assign w_tick  = (r_ps == PS_MAX);
  assign w_frame = w_tick & (r_pwm == 4'd15);
  assign w_decay = w_frame & (r_dc == DC_MAX);
  // simultaneous up and down cancel out and leave any earlier request pending
  assign w_req   = bright_up_i ^ bright_dn_i;

  assign w_bright_nxt = !(w_frame & r_pend_v) ? r_bright :
                        r_pend_up ? ((r_bright == 4'd15) ? 4'd15 : r_bright + 4'd1) :
                                    ((r_bright == 4'd1)  ? 4'd1  : r_bright - 4'd1);

  always_comb begin
    w_lvl_nxt = r_lvl;
    w_on      = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      w_on[i] = (r_pwm < r_lvl[i]);
      if (w_frame)
        w_lvl_nxt[i] = led_i[i]                    ? w_bright_nxt :
                       (r_lvl[i] > w_bright_nxt)   ? w_bright_nxt :
                       (w_decay && r_lvl[i] != '0) ? r_lvl[i] - 4'd1 : r_lvl[i];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ps      <= '0;
      r_pwm     <= '0;
      r_dc      <= '0;
      r_bright  <= 4'd15;
      r_pend_v  <= 1'b0;
      r_pend_up <= 1'b0;
      r_frame   <= 1'b0;
      r_led     <= {N_LEDS{~LED_POLARITY}};
      for (int i = 0; i < N_LEDS; i++) r_lvl[i] <= '0;
    end else begin
      r_ps    <= w_tick ? '0 : r_ps + 1'b1;
      r_pwm   <= w_tick ? r_pwm + 4'd1 : r_pwm;
      r_frame <= w_frame;
      if (w_frame) r_dc <= (r_dc == DC_MAX) ? '0 : r_dc + 1'b1;
      r_bright <= w_bright_nxt;
      if (w_req) begin
        r_pend_v  <= 1'b1;
        r_pend_up <= bright_up_i;
      end else if (w_frame) begin
        r_pend_v  <= 1'b0;
      end
      r_led <= LED_POLARITY ? w_on : ~w_on;
      r_lvl <= w_lvl_nxt;
    end
  end

  assign led_o    = r_led;
  assign bright_o = r_bright;
  assign frame_o  = r_frame;
endmodule

// File: tb/tb_led_trail_pwm.sv
// tb_led_trail_pwm: directed checks of PWM duty, decay trail, brightness stepping and polarity.
module tb_led_trail_pwm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [7:0] led, led_n;
  logic       up, dn, up_n, dn_n;
  logic [7:0] led_o, led_n_o;
  logic [3:0] bright_o, bright_n_o;
  logic       frame_o, frame_n_o;

  int checks = 0;
  int errors = 0;
  int m_on, m_oth, m_nlow, m_nhigh;

  led_trail_pwm #(.CLK_IN_MHZ(2), .N_LEDS(8), .DECAY_FRAMES(2), .LED_POLARITY(1'b1)) dut (
    .clk_i(clk), .rstn_i(rstn), .led_i(led), .bright_up_i(up), .bright_dn_i(dn),
    .led_o(led_o), .bright_o(bright_o), .frame_o(frame_o));

  led_trail_pwm #(.CLK_IN_MHZ(2), .N_LEDS(8), .DECAY_FRAMES(2), .LED_POLARITY(1'b0)) dut_n (
    .clk_i(clk), .rstn_i(rstn), .led_i(led_n), .bright_up_i(up_n), .bright_dn_i(dn_n),
    .led_o(led_n_o), .bright_o(bright_n_o), .frame_o(frame_n_o));

  task automatic wait_frame();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_o && n < 100);
    checks++;
    if (frame_o !== 1'b1) begin errors++; $display("FAIL wait_frame timeout frame_o=%b", frame_o); end
  endtask

  // samples one whole frame: starts just after a frame_o cycle and ends on the next one
  task automatic measure();
    int n = 0;
    m_on = 0; m_oth = 0; m_nlow = 0; m_nhigh = 0;
    do begin
      @(negedge clk);
      n++;
      m_on    += int'(led_o[0]);
      m_oth   += int'(led_o[7:1] != 7'd0);
      m_nlow  += int'(led_n_o == 8'h00);
      m_nhigh += int'(led_n_o == 8'hFF);
    end while (!frame_o && n < 40);
    checks++;
    if (n !== 32) begin errors++; $display("FAIL measure_len got %0d exp 32", n); end
  endtask

  task automatic pulse_dn();
    dn = 1'b1; @(negedge clk); dn = 1'b0;
  endtask

  task automatic pulse_up();
    up = 1'b1; @(negedge clk); up = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; led = 8'h00; led_n = 8'hFF; up = 0; dn = 0; up_n = 0; dn_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL rst_led got %h exp 00", led_o); end
    checks++; if (bright_o !== 4'd15) begin errors++; $display("FAIL rst_bright got %0d exp 15", bright_o); end
    checks++; if (frame_o !== 1'b0) begin errors++; $display("FAIL rst_frame got %b exp 0", frame_o); end
    checks++; if (led_n_o !== 8'hFF) begin errors++; $display("FAIL rst_led_n got %h exp FF", led_n_o); end
  endtask

  task automatic test_frame();
    int n = 0;
    rstn = 1'b1;
    do begin @(negedge clk); n++; end while (!frame_o && n < 100);
    checks++; if (n !== 32) begin errors++; $display("FAIL first_frame got %0d exp 32", n); end
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_o && n < 100);
    checks++; if (n !== 32) begin errors++; $display("FAIL frame_period got %0d exp 32", n); end
    checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL idle_led got %h exp 00", led_o); end
  endtask

  task automatic test_steady();
    led = 8'h01;
    wait_frame();
    measure();
    checks++; if (m_on !== 30) begin errors++; $display("FAIL steady_duty got %0d exp 30", m_on); end
    checks++; if (m_oth !== 0) begin errors++; $display("FAIL steady_other got %0d exp 0", m_oth); end
  endtask

  task automatic test_decay();
    int exp_on;
    led = 8'h00;
    for (int j = 0; j < 32; j++) begin
      measure();
      exp_on = (j < 30) ? 2 * (15 - j / 2) : 0;
      checks++;
      if (m_on !== exp_on) begin errors++; $display("FAIL decay_%0d got %0d exp %0d", j, m_on, exp_on); end
    end
  endtask

  task automatic test_sample();
    repeat (5) @(negedge clk);
    led = 8'h01;
    repeat (3) @(negedge clk);
    led = 8'h00;
    wait_frame();
    measure();
    checks++; if (m_on !== 0) begin errors++; $display("FAIL mid_frame_ignored got %0d exp 0", m_on); end
  endtask

  task automatic test_brightness();
    led = 8'h01;
    pulse_dn(); @(negedge clk); pulse_dn(); @(negedge clk); pulse_dn();
    wait_frame();
    checks++; if (bright_o !== 4'd14) begin errors++; $display("FAIL bright_one_step got %0d exp 14", bright_o); end
    measure();
    checks++; if (m_on !== 28) begin errors++; $display("FAIL duty_14 got %0d exp 28", m_on); end
    checks++; if (bright_o !== 4'd14) begin errors++; $display("FAIL bright_cleared got %0d exp 14", bright_o); end
    for (int k = 0; k < 7; k++) begin pulse_dn(); wait_frame(); end
    checks++; if (bright_o !== 4'd7) begin errors++; $display("FAIL bright_7 got %0d exp 7", bright_o); end
    measure();
    checks++; if (m_on !== 14) begin errors++; $display("FAIL duty_7 got %0d exp 14", m_on); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin pulse_dn(); wait_frame(); end
    checks++; if (bright_o !== 4'd1) begin errors++; $display("FAIL sat_low got %0d exp 1", bright_o); end
    measure();
    checks++; if (m_on !== 2) begin errors++; $display("FAIL duty_1 got %0d exp 2", m_on); end
    up = 1'b1; dn = 1'b1; @(negedge clk); up = 1'b0; dn = 1'b0;
    wait_frame();
    checks++; if (bright_o !== 4'd1) begin errors++; $display("FAIL both_ignored got %0d exp 1", bright_o); end
    pulse_up();
    up = 1'b1; dn = 1'b1; @(negedge clk); up = 1'b0; dn = 1'b0;
    wait_frame();
    checks++; if (bright_o !== 4'd2) begin errors++; $display("FAIL both_keeps_pending got %0d exp 2", bright_o); end
    pulse_up(); pulse_dn();
    wait_frame();
    checks++; if (bright_o !== 4'd1) begin errors++; $display("FAIL overwrite got %0d exp 1", bright_o); end
    for (int k = 0; k < 20; k++) begin pulse_up(); wait_frame(); end
    checks++; if (bright_o !== 4'd15) begin errors++; $display("FAIL sat_high got %0d exp 15", bright_o); end
  endtask

  task automatic test_polarity();
    for (int k = 0; k < 11; k++) begin
      dn_n = 1'b1; @(negedge clk); dn_n = 1'b0;
      wait_frame();
    end
    checks++; if (bright_n_o !== 4'd4) begin errors++; $display("FAIL pol_bright got %0d exp 4", bright_n_o); end
    measure();
    checks++; if (m_nlow !== 8) begin errors++; $display("FAIL pol_low got %0d exp 8", m_nlow); end
    checks++; if (m_nhigh !== 24) begin errors++; $display("FAIL pol_high got %0d exp 24", m_nhigh); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    #3 rstn = 1'b0;
    #1;
    checks++; if (led_n_o !== 8'hFF) begin errors++; $display("FAIL mid_rst_led_n got %h exp FF", led_n_o); end
    checks++; if (bright_n_o !== 4'd15) begin errors++; $display("FAIL mid_rst_bright_n got %0d exp 15", bright_n_o); end
    checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL mid_rst_led got %h exp 00", led_o); end
    @(negedge clk);
    rstn = 1'b1;
    do begin @(negedge clk); n++; end while (!frame_o && n < 100);
    checks++; if (n !== 32) begin errors++; $display("FAIL post_rst_frame got %0d exp 32", n); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_steady();
    test_decay();
    test_sample();
    test_brightness();
    test_saturation();
    test_polarity();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
